fifo_credit_rtn: RTL and testbench
==================================

Name: fifo_credit_rtn

Overview:
Parametrised synchronous FIFO with built-in credit-return logic: the next generation of the fixed 32-entry FIFO used in the credit_return example. DEPTH, WIDTH and almost-full threshold are generic. The block issues DEPTH initial credits after reset and returns one credit per accepted read, so an upstream credit counter can drive data_we without looking at full. It sits at the receive side of a credit-flow link, one instance per channel.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 16, number of entries; power of 2, 2..1024
AFULL_LVL, DEPTH-2, level at or above which almost_full is asserted (1..DEPTH)
CREDIT_INIT, 1, 1 = issue DEPTH credits after reset; 0 = no initial credits (upstream preloaded)

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
data_i  input  WIDTH  write data
data_we  input  1  write request
data_o  output  WIDTH  head-of-queue data (first-word-fall-through)
data_rd  input  1  read/pop request
full  output  1  level == DEPTH
empty  output  1  level == 0
almost_full  output  1  level >= AFULL_LVL
level  output  $clog2(DEPTH)+1  current occupancy
credit_o  output  1  one-cycle pulse = one credit returned upstream
init_done  output  1  high once initial credit issue is complete
overflow  output  1  sticky: data_we while full
underflow  output  1  sticky: data_rd while empty

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (reset_n); on assertion all pointers, level, credit state and sticky flags clear immediately. Memory contents are not reset.
- Reset values: empty=1, full=0, almost_full=0, level=0, credit_o=0, init_done=0, overflow=0, underflow=0. data_o is undefined until the first write.
- Pointers are $clog2(DEPTH)+1 bits with an extra wrap bit. full = low bits equal and wrap bits differ. empty = pointers equal. Wrap-around is natural modulo 2*DEPTH.
- A write is accepted when data_we & ~full. Data lands in mem[wr_ptr] and wr_ptr increments. Write-to-data_o latency is 1 cycle: empty deasserts on the next edge.
- A read is accepted when data_rd & ~empty. rd_ptr increments. data_o = mem[rd_ptr], combinational from the pointer.
- full and empty are evaluated on current-cycle state:
  - Read and write together when full: only the read is accepted, and overflow is set.
  - Read and write together when empty: only the write is accepted, and underflow is set.
  - Otherwise both are accepted and level is unchanged.
- level is registered and updates on the same edge as the pointers.
- Rejected requests do not change pointers. overflow/underflow are set on the next edge and are cleared only by reset.
- Credit FSM states:
  - INIT: entered after reset if CREDIT_INIT=1. credit_o pulses every cycle for exactly DEPTH cycles, starting the first cycle after reset release. Then go to RUN and set init_done.
  - RUN: entered directly if CREDIT_INIT=0, with init_done=1 one cycle after reset release.
- Return path:
  - Each accepted read increments a pending counter, pend ($clog2(DEPTH)+1 bits).
  - In RUN, credit_o=1 whenever pend>0, and pend decrements that cycle. The required latency is accepted read at edge N -> credit_o high in cycle N+1 when no backlog exists.
  - A read and a drain in the same cycle leave pend unchanged.
  - Reads accepted during INIT accumulate in pend and drain after INIT, one per cycle.
  - pend never exceeds DEPTH.
- Credit conservation: total credit_o pulses minus accepted writes always equals DEPTH - level - pend (CREDIT_INIT=1).
- Reset mid-operation: everything clears and the FSM restarts in INIT. Credits in flight upstream are the upstream's responsibility to discard.

Decomposition:
- Package fifo_pkg:
  - typedef enum logic [0:0] {CR_INIT, CR_RUN} cr_state_t
  - function ptr_w(depth) returning $clog2(depth)+1
- Sub-module fifo_credit_gen (FSM, init counter, pend counter, credit_o, init_done).
  - Inputs: rd_accept.
  - Parameters: DEPTH, CREDIT_INIT.
- Storage and pointers stay in the top module.

Test Plan:
- Reset release, WIDTH=8, DEPTH=4, CREDIT_INIT=1, no traffic -> credit_o high cycles 1..4 exactly, init_done rises after the 4th pulse, empty=1, level=0.
- Write 0x11,0x22,0x33,0x44 -> full=1, level=4, almost_full=1 (AFULL_LVL=2 from level 2 on). A 5th write of 0x55 is rejected and overflow=1. Reads return 0x11..0x44 in order, with credit_o one cycle after each read.
- At full, drive data_we=1 (0x66) and data_rd=1 in the same cycle -> read accepted and write rejected, level=3, overflow=1. With level=2, simultaneous rd+we -> level stays 2 and the order is preserved.
- 40 streaming write/read cycles wrapping the pointers several times -> data order intact, no flag errors, credit pulses = reads.
- CREDIT_INIT=1: upstream writes on the first credit and reads in cycle 2 of INIT -> pend=1 held, then the extra credit_o appears on the first RUN cycle. Total pulses = DEPTH + reads.
- Assert reset_n asynchronously mid-burst at level=3 with pend=2 -> outputs clear immediately, without waiting for clk. After release, INIT reissues DEPTH credits and the stale pend is dropped.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the credit-return FIFO.
package fifo_pkg;

   typedef enum logic [0:0] {CR_INIT, CR_RUN} cr_state_t;

   // Pointer/level width: index bits plus one wrap bit.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_credit_gen.sv
// Credit generator: issues the initial credit burst after reset, then
// returns one credit per accepted read.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   CR_INIT | pulse credit_o once per cycle until init_cnt reaches zero;
//           | reads seen here only accumulate in pend
//   CR_RUN  | init_done high; drain pend one credit per cycle
module fifo_credit_gen
   import fifo_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter bit CREDIT_INIT = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic rd_accept,
   output logic credit_o,
   output logic init_done
);

   localparam int PW = ptr_w(DEPTH);
   localparam logic [PW-1:0] INIT_CNT = PW'(DEPTH);

   cr_state_t     state;
   logic [PW-1:0] init_cnt;
   logic [PW-1:0] pend;
   logic [PW-1:0] avail;

   // Credits owed this cycle, counting a read accepted on this same edge so
   // an idle return path answers a read on the very next cycle.
   assign avail = pend + {{(PW-1){1'b0}}, rd_accept};

   // Credit FSM with down-counting init timer and pending-return counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= CREDIT_INIT ? CR_INIT : CR_RUN;
         init_cnt  <= INIT_CNT;
         pend      <= '0;
         credit_o  <= 1'b0;
         init_done <= 1'b0;
      end else begin
         case (state)
            CR_INIT: begin
               if (init_cnt != '0) begin
                  credit_o <= 1'b1;
                  init_cnt <= init_cnt - PW'(1);
                  pend     <= avail;
               end else begin
                  state     <= CR_RUN;
                  init_done <= 1'b1;
                  credit_o  <= (avail != '0);
                  pend      <= (avail != '0) ? avail - PW'(1) : '0;
               end
            end
            CR_RUN: begin
               init_done <= 1'b1;
               credit_o  <= (avail != '0);
               pend      <= (avail != '0) ? avail - PW'(1) : '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/fifo_credit_rtn.sv
// Receive-side FIFO with first-word-fall-through output and credit return.
module fifo_credit_rtn
   import fifo_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 16,
   parameter int AFULL_LVL   = DEPTH - 2,
   parameter bit CREDIT_INIT = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     data_we,
   output logic [WIDTH-1:0]         data_o,
   input  logic                     data_rd,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     credit_o,
   output logic                     init_done,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = ptr_w(DEPTH);
   localparam logic [PW-1:0] AFULL_L = PW'(AFULL_LVL);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             wr_acc;
   logic             rd_acc;

   assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign empty       = (wr_ptr == rd_ptr);
   assign wr_acc      = data_we & ~full;
   assign rd_acc      = data_rd & ~empty;
   assign almost_full = (level >= AFULL_L);
   assign data_o      = mem[rd_ptr[AW-1:0]];

   // Storage write; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr[AW-1:0]] <= data_i;
   end

   // Pointers, occupancy and sticky error flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
         case ({wr_acc, rd_acc})
            2'b10:   level <= level + PW'(1);
            2'b01:   level <= level - PW'(1);
            default: level <= level;
         endcase
         if (data_we && full)  overflow  <= 1'b1;
         if (data_rd && empty) underflow <= 1'b1;
      end
   end

   fifo_credit_gen #(
      .DEPTH       (DEPTH),
      .CREDIT_INIT (CREDIT_INIT)
   ) u_credit_gen (
      .clk       (clk),
      .reset_n   (reset_n),
      .rd_accept (rd_acc),
      .credit_o  (credit_o),
      .init_done (init_done)
   );

endmodule

// File: tb/tb_fifo_credit_rtn.sv
// Directed bench for fifo_credit_rtn (WIDTH=8, DEPTH=4, AFULL_LVL=2).
module tb_fifo_credit_rtn;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int AFULL = 2;

   logic             clk;
   logic             reset_n;
   logic [WIDTH-1:0] data_i;
   logic             data_we;
   logic [WIDTH-1:0] data_o;
   logic             data_rd;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic [2:0]       level;
   logic             credit_o;
   logic             init_done;
   logic             overflow;
   logic             underflow;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] sb [$];
   int m_lvl, m_cnt, m_pend, n_cr, n_wr, n_rd;
   bit m_ovf, m_unf, m_init, m_done;

   fifo_credit_rtn #(
      .WIDTH       (WIDTH),
      .DEPTH       (DEPTH),
      .AFULL_LVL   (AFULL),
      .CREDIT_INIT (1'b1)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .data_i      (data_i),
      .data_we     (data_we),
      .data_o      (data_o),
      .data_rd     (data_rd),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .level       (level),
      .credit_o    (credit_o),
      .init_done   (init_done),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Assert reset between clock edges, confirm outputs clear at once, release on a falling edge.
   task automatic async_reset();
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_level", 32'(level), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_afull", 32'(almost_full), 0);
      chk("rst_credit", 32'(credit_o), 0);
      chk("rst_init_done", 32'(init_done), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_underflow", 32'(underflow), 0);
      sb.delete();
      m_lvl = 0; m_cnt = DEPTH; m_pend = 0;
      n_cr = 0; n_wr = 0; n_rd = 0;
      m_ovf = 0; m_unf = 0; m_init = 1; m_done = 0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // One clock cycle of stimulus, then model update and output checks.
   task automatic step(input bit we, input logic [WIDTH-1:0] d, input bit rd);
      bit wacc, racc, ecr;
      int avail;
      wacc = we && (m_lvl != DEPTH);
      racc = rd && (m_lvl != 0);
      if (racc) begin
         chk("data_o", 32'(data_o), 32'(sb[0]));
         void'(sb.pop_front());
      end
      if (we && m_lvl == DEPTH) m_ovf = 1;
      if (rd && m_lvl == 0) m_unf = 1;
      data_we = we; data_i = d; data_rd = rd;
      @(posedge clk);
      @(negedge clk);
      data_we = 1'b0; data_rd = 1'b0;
      if (wacc) sb.push_back(d);
      m_lvl = m_lvl + int'(wacc) - int'(racc);
      n_wr += int'(wacc);
      n_rd += int'(racc);
      ecr = 0;
      if (m_init && m_cnt > 0) begin
         ecr = 1;
         m_cnt--;
         m_pend += int'(racc);
      end else begin
         if (m_init) begin
            m_init = 0;
            m_done = 1;
         end
         avail  = m_pend + int'(racc);
         ecr    = (avail > 0);
         m_pend = avail - int'(ecr);
      end
      if (credit_o === 1'b1) n_cr++;
      chk("level", 32'(level), 32'(m_lvl));
      chk("full", 32'(full), 32'(m_lvl == DEPTH));
      chk("empty", 32'(empty), 32'(m_lvl == 0));
      chk("almost_full", 32'(almost_full), 32'(m_lvl >= AFULL));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
      chk("credit_o", 32'(credit_o), 32'(ecr));
      chk("init_done", 32'(init_done), 32'(m_done));
      if (m_done) chk("conserve", 32'(n_cr - n_wr), 32'(DEPTH - m_lvl - m_pend));
   endtask

   initial begin
      reset_n = 1'b1;
      data_we = 1'b0;
      data_rd = 1'b0;
      data_i  = '0;

      // Initial credit burst with no traffic.
      async_reset();
      for (int i = 0; i < DEPTH + 2; i++) step(0, 8'h00, 0);
      chk("init_pulses", 32'(n_cr), 32'(DEPTH));

      // Fill to full, rejected fifth write, drain in order.
      step(1, 8'h11, 0);
      step(1, 8'h22, 0);
      step(1, 8'h33, 0);
      step(1, 8'h44, 0);
      step(1, 8'h55, 0);
      for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1);

      // Simultaneous read/write at full and at level 2.
      step(1, 8'h01, 0);
      step(1, 8'h02, 0);
      step(1, 8'h03, 0);
      step(1, 8'h04, 0);
      step(1, 8'h66, 1);
      step(0, 8'h00, 1);
      step(1, 8'h77, 1);
      step(0, 8'h00, 1);
      step(0, 8'h00, 1);

      // Streaming traffic wrapping the pointers.
      step(1, 8'($urandom), 0);
      for (int i = 0; i < 40; i++) step(1, 8'($urandom), 1);
      step(0, 8'h00, 1);
      chk("stream_credits", 32'(n_cr), 32'(DEPTH + n_rd));

      // Traffic inside INIT, then reset while reads are still pending.
      async_reset();
      step(0, 8'h00, 0);
      step(1, 8'hA1, 0);
      step(1, 8'hA2, 1);
      step(1, 8'hA3, 1);
      chk("pend_before_reset", 32'(m_pend), 2);
      async_reset();

      // Fresh INIT: write on first credit, read in INIT, extra credit after.
      step(0, 8'h00, 0);
      step(1, 8'hB1, 0);
      step(0, 8'h00, 1);
      step(0, 8'h00, 0);
      step(0, 8'h00, 0);
      step(0, 8'h00, 0);
      step(0, 8'h00, 0);
      chk("init_plus_reads", 32'(n_cr), 32'(DEPTH + n_rd));

      // Read while empty sets the sticky underflow flag.
      step(0, 8'h00, 1);
      step(0, 8'h00, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
